// File: rtl/jtag_tap_pkg.sv
// Shared types and helpers for the oversampled JTAG TAP: IEEE state encoding,
// standard TMS next-state function and instruction code helpers.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR        = 4'hF,
    RTI        = 4'hC,
    SELECT_DR  = 4'h7,
    CAPTURE_DR = 4'h6,
    SHIFT_DR   = 4'h2,
    EXIT1_DR   = 4'h1,
    PAUSE_DR   = 4'h3,
    EXIT2_DR   = 4'h0,
    UPDATE_DR  = 4'h5,
    SELECT_IR  = 4'h4,
    CAPTURE_IR = 4'hE,
    SHIFT_IR   = 4'hA,
    EXIT1_IR   = 4'h9,
    PAUSE_IR   = 4'hB,
    EXIT2_IR   = 4'h8,
    UPDATE_IR  = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  localparam int unsigned IDCODE_LEN = 32;

  function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
    case (state)
      TLR:        return tms ? TLR       : RTI;
      RTI:        return tms ? SELECT_DR : RTI;
      SELECT_DR:  return tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: return tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   return tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   return tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   return tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   return tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  return tms ? SELECT_DR : RTI;
      SELECT_IR:  return tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: return tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   return tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   return tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   return tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   return tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  return tms ? SELECT_DR : RTI;
      default:    return TLR;
    endcase
  endfunction

  // Instruction codes are returned 32 bits wide; callers truncate to IR_WIDTH.
  function automatic logic [31:0] ir_code_idcode();
    return 32'd1;
  endfunction

  function automatic logic [31:0] ir_code_bypass(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [31:0] ir_code_user(input int unsigned k);
    return 32'd2 + 32'(k);
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchronisers for tck/tms/tdi plus a delay flop for tck edge detect.
// Edges are suppressed until a genuine synced low level has been seen after reset.
module jtag_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tms_s,
  output logic tdi_s,
  output logic tck_rise,
  output logic tck_fall
);

  logic [1:0] tck_sync;
  logic [1:0] tms_sync;
  logic [1:0] tdi_sync;
  logic       tck_d;
  logic       valid_1;
  logic       valid_2;
  logic       armed;

  // NOTE: every clocked block uses non-blocking assignments so that all flops
  // sample the pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
      valid_1  <= 1'b0;
      valid_2  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], tck};
      tms_sync <= {tms_sync[0], tms};
      tdi_sync <= {tdi_sync[0], tdi};
      tck_d    <= tck_sync[1];
      valid_1  <= 1'b1;
      valid_2  <= valid_1;
      // The reset value of the chain is not a real sample, so wait for one.
      armed    <= armed | (valid_2 & ~tck_sync[1]);
    end
  end

  assign tck_rise = armed &  tck_sync[1] & ~tck_d;
  assign tck_fall = armed & ~tck_sync[1] &  tck_d;
  assign tms_s    = tms_sync[1];
  assign tdi_s    = tdi_sync[1];

endmodule

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP with IDCODE, BYPASS and NUM_USER_DR user registers, run from clk.
// Define JTAG_TAP_DEBUG_EN to expose tap_state and ir_value.
module jtag_tap_multi
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE        = 32'h1000_0FFF,
  parameter int unsigned NUM_USER_DR   = 2,
  parameter int unsigned USER_DR_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   tck,
  input  logic                                   tms,
  input  logic                                   tdi,
  output logic                                   tdo,
  output logic                                   tdo_oe,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_in,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_out,
  output logic [NUM_USER_DR-1:0]                 user_update
`ifdef JTAG_TAP_DEBUG_EN
  ,
  output logic [3:0]                             tap_state,
  output logic [IR_WIDTH-1:0]                    ir_value
`endif
);

  localparam int unsigned IDX_W = (NUM_USER_DR > 1) ? $clog2(NUM_USER_DR) : 1;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(ir_code_idcode());
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic                     tms_s;
  logic                     tdi_s;
  logic                     tck_rise;
  logic                     tck_fall;
  tap_state_t               state;
  tap_state_t               state_nxt;
  logic [IR_WIDTH-1:0]      ir;
  logic [IR_WIDTH-1:0]      ir_sr;
  logic [IDCODE_LEN-1:0]    idcode_sr;
  logic                     bypass_sr;
  logic [USER_DR_WIDTH-1:0] user_sr;
  logic [31:0]              ir_ext;
  dr_sel_t                  dr_sel;
  logic [IDX_W-1:0]         user_idx;
  logic [31:0]              user_base;
  logic                     dr_lsb;
  logic                     in_shift;

  jtag_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= TLR;
    else        state <= state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (tck_rise) state_nxt = tap_next(state, tms_s);
  end

  // Unlisted codes (including 0 and all-ones) fall through to BYPASS.
  assign ir_ext = 32'(ir);
  always_comb begin
    dr_sel   = DR_BYPASS;
    user_idx = '0;
    if (ir == IR_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (ir_ext >= ir_code_user(0) && ir_ext < ir_code_user(NUM_USER_DR)) begin
      dr_sel   = DR_USER;
      user_idx = IDX_W'(ir_ext - ir_code_user(0));
    end
  end

  assign user_base = 32'(user_idx) * USER_DR_WIDTH;
  assign in_shift  = (state == SHIFT_DR) || (state == SHIFT_IR);

  always_comb begin
    dr_lsb = bypass_sr;
    case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_sr[0];
      DR_USER:   dr_lsb = user_sr[0];
      default:   dr_lsb = bypass_sr;
    endcase
  end

  // Capture and shift happen on tck_rise, keyed on the state before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_sr     <= '0;
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
      user_sr   <= '0;
    end else if (tck_rise) begin
      case (state)
        CAPTURE_IR: ir_sr <= IR_CAPTURE;
        SHIFT_IR:   ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
        CAPTURE_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr <= IDCODE;
            DR_USER:   user_sr   <= user_dr_in[user_base +: USER_DR_WIDTH];
            default:   bypass_sr <= 1'b0;
          endcase
        end
        SHIFT_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr <= {tdi_s, idcode_sr[IDCODE_LEN-1:1]};
            DR_USER:   user_sr   <= (user_sr >> 1) |
                                    (USER_DR_WIDTH'(tdi_s) << (USER_DR_WIDTH - 1));
            default:   bypass_sr <= tdi_s;
          endcase
        end
        default: ;
      endcase
    end
  end

  // tdo and the update stages act on tck_fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdo         <= 1'b0;
      tdo_oe      <= 1'b0;
      ir          <= IR_IDCODE;
      user_dr_out <= '0;
      user_update <= '0;
    end else begin
      user_update <= '0;
      if (state == TLR) ir <= IR_IDCODE;

      if (tck_fall && in_shift) begin
        tdo    <= (state == SHIFT_IR) ? ir_sr[0] : dr_lsb;
        tdo_oe <= 1'b1;
      end else if (!in_shift) begin
        tdo_oe <= 1'b0;
      end

      if (tck_fall && state == UPDATE_IR) ir <= ir_sr;

      // user_dr_out is only touched here, so Test-Logic-Reset leaves it intact.
      if (tck_fall && state == UPDATE_DR && dr_sel == DR_USER) begin
        user_dr_out[user_base +: USER_DR_WIDTH] <= user_sr;
        user_update[user_idx]                   <= 1'b1;
      end
    end
  end

`ifdef JTAG_TAP_DEBUG_EN
  assign tap_state = state;
  assign ir_value  = ir;
`endif

endmodule
